// File: rtl/hub75_scan_ctrl_pkg.sv
// Shared definitions for the HUB75 scan controller: FSM state encodings
// and the width helper used to size row/plane buses.
package hub75_scan_ctrl_pkg;

    // FSM state encodings, kept as plain constants so legacy tools and
    // waveform viewers see stable numeric codes.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHIFT = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_LATCH = 3'd3;
    localparam logic [2:0] ST_SHOW  = 3'd4;

    // Bits needed to index v items, never less than 1 so that a single
    // plane or row still gets a legal one-bit bus.
    function automatic int log2_w(input int v);
        int w;
        w = 1;
        while ((1 << w) < v) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/hub75_scan_ctrl_if.sv
// Handshake bundle between the scan controller and the row shifter /
// blanking unit. The controller is the master side.
interface hub75_scan_ctrl_if
    import hub75_scan_ctrl_pkg::*;
#(
    parameter int N_ROWS   = 32,
    parameter int N_PLANES = 8
);
    localparam int ROW_W   = log2_w(N_ROWS);
    localparam int PLANE_W = log2_w(N_PLANES);

    // Shifter request/idle
    logic                shift_go;
    logic [ROW_W-1:0]    shift_row;
    logic [PLANE_W-1:0]  shift_plane;
    logic                shift_rdy;

    // Blanking unit start/idle
    logic                blank_go;
    logic [N_PLANES-1:0] blank_plane;
    logic                blank_rdy;

    modport master (
        output shift_go, shift_row, shift_plane, blank_go, blank_plane,
        input  shift_rdy, blank_rdy
    );

    modport slave (
        input  shift_go, shift_row, shift_plane, blank_go, blank_plane,
        output shift_rdy, blank_rdy
    );

endinterface

// File: rtl/hub75_scan_cnt.sv
// Row/plane position counter for the scan. Plane is the fast digit,
// row the slow one; o_last flags the final plane of the final row.
module hub75_scan_cnt
    import hub75_scan_ctrl_pkg::*;
#(
    parameter int N_ROWS   = 32,
    parameter int N_PLANES = 8,
    localparam int ROW_W   = log2_w(N_ROWS),
    localparam int PLANE_W = log2_w(N_PLANES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_adv,
    output logic [ROW_W-1:0]   o_row,
    output logic [PLANE_W-1:0] o_plane,
    output logic               o_last
);

    logic [ROW_W-1:0]   r_row;
    logic [PLANE_W-1:0] r_plane;
    logic               w_row_last;
    logic               w_plane_last;

    assign w_row_last   = (r_row   == ROW_W'(N_ROWS - 1));
    assign w_plane_last = (r_plane == PLANE_W'(N_PLANES - 1));

    // Advance plane, carry into row, wrap both at their last value.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every
        // flop samples the pre-edge value, independent of block ordering.
        if (rst) begin
            r_row   <= '0;
            r_plane <= '0;
        end else if (i_clr) begin
            r_row   <= '0;
            r_plane <= '0;
        end else if (i_adv) begin
            if (w_plane_last) begin
                r_plane <= '0;
                r_row   <= w_row_last ? '0 : r_row + ROW_W'(1);
            end else begin
                r_plane <= r_plane + PLANE_W'(1);
            end
        end
    end

    assign o_row   = r_row;
    assign o_plane = r_plane;
    assign o_last  = w_row_last & w_plane_last;

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 panel scan controller. Sequences one row/plane step at a time:
// shift the next data into the panel while the previous plane is still
// on display, wait for both shifter and blanking unit to go idle, latch
// and re-address the panel, then start the BCM display period.
module hub75_scan_ctrl
    import hub75_scan_ctrl_pkg::*;
#(
    parameter int N_ROWS   = 32,
    parameter int N_PLANES = 8,
    localparam int ROW_W   = log2_w(N_ROWS),
    localparam int PLANE_W = log2_w(N_PLANES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_run,
    output logic              frame_end,
    output logic [ROW_W-1:0]  hub75_addr,
    output logic              hub75_le,
    hub75_scan_ctrl_if.master scan
);

    logic [2:0]          r_state;
    logic                r_shift_go;
    logic                r_blank_go;
    logic                r_hub75_le;
    logic                r_frame_end;
    logic [ROW_W-1:0]    r_hub75_addr;
    logic [N_PLANES-1:0] r_blank_plane;

    logic [ROW_W-1:0]    w_row;
    logic [PLANE_W-1:0]  w_plane;
    logic                w_frame_last;
    logic                w_cnt_clr;
    logic                w_cnt_adv;
    logic [N_PLANES-1:0] w_plane_code;

    // Counters only move at the end of a display start and are held at
    // zero while idle, so a restart always begins at row 0, plane 0.
    assign w_cnt_clr = (r_state == ST_IDLE);
    assign w_cnt_adv = (r_state == ST_SHOW);

    hub75_scan_cnt #(
        .N_ROWS   (N_ROWS),
        .N_PLANES (N_PLANES)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_cnt_clr),
        .i_adv   (w_cnt_adv),
        .o_row   (w_row),
        .o_plane (w_plane),
        .o_last  (w_frame_last)
    );

    // Display-length code: plane p shows for 2^p units, i.e. p low ones.
    always_comb begin
        // NOTE: default first so no path leaves the vector unassigned,
        // which would otherwise infer a latch.
        w_plane_code = '0;
        for (int i = 0; i < N_PLANES; i++) begin
            if (i < int'(w_plane)) begin
                w_plane_code[i] = 1'b1;
            end
        end
    end

    // Scan FSM; each pulse is set on entry to its state so it is high for
    // exactly the one cycle spent in that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_shift_go    <= 1'b0;
            r_blank_go    <= 1'b0;
            r_hub75_le    <= 1'b0;
            r_frame_end   <= 1'b0;
            r_hub75_addr  <= '0;
            r_blank_plane <= '0;
        end else begin
            r_shift_go  <= 1'b0;
            r_blank_go  <= 1'b0;
            r_hub75_le  <= 1'b0;
            r_frame_end <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ctrl_run) begin
                        r_state    <= ST_SHIFT;
                        r_shift_go <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Address may only change while the panel is blanked.
                    if (scan.shift_rdy && scan.blank_rdy) begin
                        r_state      <= ST_LATCH;
                        r_hub75_le   <= 1'b1;
                        r_hub75_addr <= w_row;
                    end
                end
                ST_LATCH: begin
                    r_state       <= ST_SHOW;
                    r_blank_go    <= 1'b1;
                    r_blank_plane <= w_plane_code;
                    r_frame_end   <= w_frame_last;
                end
                ST_SHOW: begin
                    // Stop requests are honoured only at a frame boundary;
                    // otherwise start shifting the next step immediately so
                    // it overlaps the display period just started.
                    if (w_frame_last && !ctrl_run) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state    <= ST_SHIFT;
                        r_shift_go <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign scan.shift_go    = r_shift_go;
    assign scan.shift_row   = w_row;
    assign scan.shift_plane = w_plane;
    assign scan.blank_go    = r_blank_go;
    assign scan.blank_plane = r_blank_plane;
    assign hub75_le         = r_hub75_le;
    assign hub75_addr       = r_hub75_addr;
    assign frame_end        = r_frame_end;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl with a 4-row, 3-plane panel.
module tb_hub75_scan_ctrl;

    localparam int NR = 4;
    localparam int NP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ctrl_run = 1'b0;
    logic       frame_end;
    logic [1:0] hub75_addr;
    logic       hub75_le;

    hub75_scan_ctrl_if #(.N_ROWS(NR), .N_PLANES(NP)) scan ();

    hub75_scan_ctrl #(
        .N_ROWS   (NR),
        .N_PLANES (NP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_run   (ctrl_run),
        .frame_end  (frame_end),
        .hub75_addr (hub75_addr),
        .hub75_le   (hub75_le),
        .scan       (scan)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait for a pulse at a negedge: 0 shift_go, 1 hub75_le, 2 blank_go, 3 frame_end.
    task automatic wait_pulse(input string tag, input int which, input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            case (which)
                0:       seen = scan.shift_go;
                1:       seen = hub75_le;
                2:       seen = scan.blank_go;
                default: seen = frame_end;
            endcase
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
    endtask

    // blank_rdy as the DUT saw it at the most recent rising edge.
    logic smp_blank_rdy = 1'b0;
    always @(posedge clk) smp_blank_rdy <= scan.blank_rdy;

    // Step-order monitor with its own row/plane model.
    initial begin
        int ph, er, ep, np;
        logic [1:0] prev_addr;
        ph = 0; er = 0; ep = 0; prev_addr = 2'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ph = 0; er = 0; ep = 0;
                prev_addr = hub75_addr;
            end else begin
                np = int'(scan.shift_go) + int'(hub75_le) + int'(scan.blank_go);
                if (np != 0) check("pulse_exclusive", np, 1);
                if (hub75_addr != prev_addr) begin
                    check("addr_chg_blank_rdy", int'(smp_blank_rdy), 1);
                    check("addr_chg_le", int'(hub75_le), 1);
                end
                prev_addr = hub75_addr;
                if (scan.shift_go) begin
                    check("order_shift", ph, 0);
                    check("shift_row", int'(scan.shift_row), er);
                    check("shift_plane", int'(scan.shift_plane), ep);
                    ph = 1;
                end
                if (hub75_le) begin
                    check("order_le", ph, 1);
                    check("le_addr", int'(hub75_addr), er);
                    ph = 2;
                end
                if (scan.blank_go) begin
                    check("order_blank", ph, 2);
                    check("blank_plane", int'(scan.blank_plane), (1 << ep) - 1);
                    check("frame_end_at_last", int'(frame_end), int'(er == NR - 1 && ep == NP - 1));
                    if (ep == NP - 1) begin
                        ep = 0;
                        er = (er == NR - 1) ? 0 : er + 1;
                    end else begin
                        ep = ep + 1;
                    end
                    ph = 0;
                end
                if (frame_end) check("frame_end_with_blank_go", int'(scan.blank_go), 1);
            end
        end
    end

    initial begin
        bit seen, hit;
        int nb, nfe, nsh, nle, npl;
        logic [1:0] a0, srow;

        scan.shift_rdy = 1'b1;
        scan.blank_rdy = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_shift_go", int'(scan.shift_go), 0);
        check("rst_blank_go", int'(scan.blank_go), 0);
        check("rst_le", int'(hub75_le), 0);
        check("rst_frame_end", int'(frame_end), 0);
        check("rst_addr", int'(hub75_addr), 0);
        check("rst_blank_plane", int'(scan.blank_plane), 0);
        check("rst_shift_row", int'(scan.shift_row), 0);
        check("rst_shift_plane", int'(scan.shift_plane), 0);

        // First step latency with both units idle: SHIFT, WAIT, LATCH, SHOW
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk); ctrl_run = 1'b1;
        @(negedge clk); check("first_shift_go", int'(scan.shift_go), 1);
        @(negedge clk); check("wait_no_le", int'(hub75_le), 0);
        @(negedge clk); check("latch_le", int'(hub75_le), 1);
        check("latch_addr", int'(hub75_addr), 0);
        @(negedge clk); check("show_blank_go", int'(scan.blank_go), 1);
        check("show_code_p0", int'(scan.blank_plane), 0);

        // Two full frames: frame_end on every 12th blank_go
        nb = 1; nfe = 0;
        for (int i = 0; i < 400 && nb < 24; i++) begin
            @(negedge clk);
            if (scan.blank_go) nb++;
            if (frame_end) begin
                nfe++;
                check("frame_end_position", nb % 12, 0);
            end
        end
        check("two_frames_blank", nb, 24);
        check("two_frames_fe", nfe, 2);

        // blank_rdy held low in WAIT for 50 cycles
        wait_pulse("stall_shift", 0, 20, seen);
        srow = scan.shift_row;
        scan.blank_rdy = 1'b0;
        a0 = hub75_addr;
        nle = 0; npl = 0;
        repeat (50) begin
            @(negedge clk);
            if (hub75_le) nle++;
            if (scan.shift_go || scan.blank_go || frame_end) npl++;
        end
        check("stall_no_le", nle, 0);
        check("stall_no_pulse", npl, 0);
        check("stall_addr_hold", int'(hub75_addr), int'(a0));
        scan.blank_rdy = 1'b1;
        @(negedge clk);
        check("unstall_le", int'(hub75_le), 1);
        check("unstall_addr", int'(hub75_addr), int'(srow));

        // Drop ctrl_run at row 1, plane 2
        wait_pulse("frame_sync", 3, 100, seen);
        hit = 1'b0; seen = 1'b1;
        for (int i = 0; i < 20 && !hit && seen; i++) begin
            wait_pulse("find_r1p2", 0, 20, seen);
            if (seen && scan.shift_row == 2'd1 && scan.shift_plane == 2'd2) hit = 1'b1;
        end
        check("found_r1p2", int'(hit), 1);
        ctrl_run = 1'b0;
        nb = 0; nfe = 0;
        for (int i = 0; i < 200 && nfe == 0; i++) begin
            @(negedge clk);
            if (scan.blank_go) nb++;
            if (frame_end) nfe++;
        end
        check("stop_blank_count", nb, 7);
        check("stop_frame_end", nfe, 1);
        nsh = 0; nb = 0;
        repeat (30) begin
            @(negedge clk);
            if (scan.shift_go) nsh++;
            if (scan.blank_go) nb++;
        end
        check("idle_no_shift", nsh, 0);
        check("idle_no_blank", nb, 0);

        // Reset during SHOW at row 2
        ctrl_run = 1'b1;
        hit = 1'b0; seen = 1'b1;
        for (int i = 0; i < 20 && !hit && seen; i++) begin
            wait_pulse("find_r2", 0, 20, seen);
            if (seen && scan.shift_row == 2'd2) hit = 1'b1;
        end
        check("found_r2", int'(hit), 1);
        wait_pulse("r2_show", 2, 10, seen);
        #2 rst = 1'b1;
        #1;
        check("arst_blank_go", int'(scan.blank_go), 0);
        check("arst_addr", int'(hub75_addr), 0);
        check("arst_le", int'(hub75_le), 0);
        check("arst_shift_go", int'(scan.shift_go), 0);
        check("arst_frame_end", int'(frame_end), 0);
        check("arst_blank_plane", int'(scan.blank_plane), 0);
        check("arst_shift_row", int'(scan.shift_row), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("restart_shift_go", int'(scan.shift_go), 1);
        check("restart_row", int'(scan.shift_row), 0);
        check("restart_plane", int'(scan.shift_plane), 0);

        // Random shifter/blanking stalls over three frames
        nb = 0; nfe = 0;
        for (int i = 0; i < 6000 && nfe < 3; i++) begin
            @(negedge clk);
            if (scan.blank_go) nb++;
            if (frame_end) nfe++;
            scan.shift_rdy = ($urandom_range(0, 3) != 0);
            scan.blank_rdy = ($urandom_range(0, 2) != 0);
        end
        check("random_frames", nfe, 3);
        check("random_blank_count", nb, 36);

        scan.shift_rdy = 1'b1;
        scan.blank_rdy = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
